// File: rtl/layer2_conv_seq.sv
// Layer 2 tile sequencer: walks output tiles, streams KSIZE x KSIZE taps to the
// PE array, waits out the PE pipeline and hands each tile to the result writer.
module layer2_conv_seq #(
  parameter int unsigned KSIZE    = 5,
  parameter int unsigned OUT_H    = 8,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned PAR      = 4,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_res_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pe_clear,
  output logic       o_pe_valid,
  output logic [4:0] o_w_addr,
  output logic [7:0] o_fm_row,
  output logic [7:0] o_fm_col,
  output logic       o_res_valid,
  output logic [7:0] o_res_row,
  output logic [7:0] o_res_col
);

  localparam int unsigned CW   = 8;
  localparam int unsigned AW   = 5;
  localparam int unsigned TAPS = KSIZE * KSIZE;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [CW-1:0] TAP_LAST = CW'(KSIZE - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - PAR);
  localparam logic [CW-1:0] LAST_ROW = CW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_STEP = CW'(PAR);
  localparam logic [CW-1:0] DRN_LAST = CW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tile_row_q, tile_row_d;
  logic [CW-1:0] tile_col_q, tile_col_d;
  logic [CW-1:0] tap_r_q, tap_r_d;
  logic [CW-1:0] tap_c_q, tap_c_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [CW-1:0] drn_q, drn_d;
  logic [CW-1:0] fm_row_q, fm_row_d;
  logic [CW-1:0] fm_col_q, fm_col_d;
  logic          busy_q, done_q, clear_q, valid_q, res_valid_q;

  // Next-state and counter update; abort freezes counters and returns to IDLE.
  always_comb begin
    state_d    = state_q;
    tile_row_d = tile_row_q;
    tile_col_d = tile_col_q;
    tap_r_d    = tap_r_q;
    tap_c_d    = tap_c_q;
    w_addr_d   = w_addr_q;
    drn_d      = drn_q;
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          tile_row_d = '0;
          tile_col_d = '0;
          tap_r_d    = '0;
          tap_c_d    = '0;
          w_addr_d   = '0;
          drn_d      = '0;
          if (i_start && !i_abort) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          tap_r_d  = '0;
          tap_c_d  = '0;
          w_addr_d = '0;
          state_d  = S_MAC;
        end
        S_MAC: begin
          if (w_addr_q == LAST_TAP) begin
            drn_d   = '0;
            state_d = S_DRAIN;
          end else begin
            w_addr_d = w_addr_q + AW'(1);
            if (tap_c_q == TAP_LAST) begin
              tap_c_d = '0;
              tap_r_d = tap_r_q + CW'(1);
            end else begin
              tap_c_d = tap_c_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drn_q == DRN_LAST) state_d = S_WRITE;
          else                   drn_d   = drn_q + CW'(1);
        end
        S_WRITE: begin
          if (i_res_ready) begin
            if ((tile_row_q == LAST_ROW) && (tile_col_q == LAST_COL)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CLEAR;
              if (tile_col_q == LAST_COL) begin
                tile_col_d = '0;
                tile_row_d = tile_row_q + CW'(1);
              end else begin
                tile_col_d = tile_col_q + COL_STEP;
              end
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Feature-map coordinates track the next tile/tap so they line up with the state.
  always_comb begin
    fm_row_d = tile_row_d + tap_r_d;
    fm_col_d = tile_col_d + tap_c_d;
  end

  // State, counters and Moore outputs, all registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tile_row_q  <= '0;
      tile_col_q  <= '0;
      tap_r_q     <= '0;
      tap_c_q     <= '0;
      w_addr_q    <= '0;
      drn_q       <= '0;
      fm_row_q    <= '0;
      fm_col_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_q     <= 1'b0;
      valid_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_row_q  <= tile_row_d;
      tile_col_q  <= tile_col_d;
      tap_r_q     <= tap_r_d;
      tap_c_q     <= tap_c_d;
      w_addr_q    <= w_addr_d;
      drn_q       <= drn_d;
      fm_row_q    <= fm_row_d;
      fm_col_q    <= fm_col_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      clear_q     <= (state_d == S_CLEAR);
      valid_q     <= (state_d == S_MAC);
      res_valid_q <= (state_d == S_WRITE);
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pe_clear  = clear_q;
  assign o_pe_valid  = valid_q;
  assign o_w_addr    = w_addr_q;
  assign o_fm_row    = fm_row_q;
  assign o_fm_col    = fm_col_q;
  assign o_res_valid = res_valid_q;
  assign o_res_row   = tile_row_q;
  assign o_res_col   = tile_col_q;

endmodule

// File: tb/tb_layer2_conv_seq.sv
// Self-checking bench for layer2_conv_seq against a tile/cycle-index reference model.
module tb_layer2_conv_seq;

  localparam int K    = 5;
  localparam int OH   = 8;
  localparam int OW   = 8;
  localparam int P    = 4;
  localparam int PL   = 2;
  localparam int TAPS = K * K;
  localparam int WC   = TAPS + PL + 2;   // local cycle of a tile's first WRITE cycle
  localparam int TPR  = OW / P;          // tiles per output row
  localparam int NT   = OH * TPR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready = 1'b0;
  logic       o_busy, o_done, o_pe_clear, o_pe_valid, o_res_valid;
  logic [4:0] o_w_addr;
  logic [7:0] o_fm_row, o_fm_col, o_res_row, o_res_col;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_len = -1;
  // Reference model: phase 0 idle, 1 inside a tile, 2 done pulse.
  int m_phase = 0;
  int m_k = 0;
  int m_c = 0;

  layer2_conv_seq #(.KSIZE(K), .OUT_H(OH), .OUT_W(OW), .PAR(P), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_res_ready(ready),
    .o_busy(o_busy), .o_done(o_done), .o_pe_clear(o_pe_clear), .o_pe_valid(o_pe_valid),
    .o_w_addr(o_w_addr), .o_fm_row(o_fm_row), .o_fm_col(o_fm_col),
    .o_res_valid(o_res_valid), .o_res_row(o_res_row), .o_res_col(o_res_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    if (!rst_n) m_phase = 0;
    else if (m_phase == 0) begin
      if (start && !abort) begin
        m_phase = 1; m_k = 0; m_c = 1; start_cyc = cyc - 1;
      end
    end
    else if (abort) m_phase = 0;
    else if (m_phase == 2) m_phase = 0;
    else if (m_c == WC) begin
      if (ready) begin
        if (m_k == NT - 1) m_phase = 2;
        else begin m_k++; m_c = 1; end
      end
    end
    else m_c++;
  endtask

  task automatic check_out();
    bit in_tile, mac, wr;
    int tap, row, col;
    in_tile = (m_phase == 1);
    mac     = in_tile && (m_c >= 2) && (m_c <= TAPS + 1);
    wr      = in_tile && (m_c == WC);
    tap     = m_c - 2;
    row     = m_k / TPR;
    col     = (m_k % TPR) * P;
    chk("busy", o_busy, m_phase != 0);
    chk("pe_clear", o_pe_clear, in_tile && (m_c == 1));
    chk("pe_valid", o_pe_valid, mac);
    chk("res_valid", o_res_valid, wr);
    chk("done", o_done, m_phase == 2);
    if (mac) begin
      chk("w_addr", o_w_addr, tap);
      chk("fm_row", o_fm_row, row + tap / K);
      chk("fm_col", o_fm_col, col + tap % K);
    end
    if (wr) begin
      chk("res_row", o_res_row, row);
      chk("res_col", o_res_col, col);
    end
    if (o_done === 1'b1) done_len = cyc - start_cyc;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_out();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_clear"}, o_pe_clear, 0);
    chk({tag, "_valid"}, o_pe_valid, 0);
    chk({tag, "_w_addr"}, o_w_addr, 0);
    chk({tag, "_fm_row"}, o_fm_row, 0);
    chk({tag, "_fm_col"}, o_fm_col, 0);
    chk({tag, "_res_valid"}, o_res_valid, 0);
    chk({tag, "_res_row"}, o_res_row, 0);
    chk({tag, "_res_col"}, o_res_col, 0);
  endtask

  // Run one pass (caller raises start) until the model is idle again.
  task automatic run_pass(input string tag, input int stall_k, input int stall_n,
                          input bit rnd, input int poke, input int exp_len);
    bit finished;
    finished = 0;
    done_len = -1;
    for (int i = 0; i < 3000; i++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      else if (m_phase == 1 && m_k == stall_k && m_c == WC && stall_n > 0) begin
        ready = 1'b0; stall_n--;
      end else ready = 1'b1;
      if (i == poke) start = 1'b1;
      step();
      start = 1'b0;
      if (m_phase == 0) begin finished = 1; break; end
    end
    chk({tag, "_finished"}, finished, 1);
    if (exp_len > 0) chk({tag, "_len"}, done_len, exp_len);
    else chk({tag, "_done_seen"}, done_len > 0, 1);
  endtask

  // Run with ready high until the model reaches tile k, local cycle c.
  task automatic run_until(input string tag, input int k, input int c);
    bit hit;
    hit = 0;
    for (int i = 0; i < 3000; i++) begin
      ready = 1'b1;
      step();
      start = 1'b0;
      if (m_phase == 1 && m_k == k && m_c == c) begin hit = 1; break; end
    end
    chk({tag, "_reached"}, hit, 1);
  endtask

  initial begin
    // Reset and idle
    #1;
    chk_zero("rst");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();

    // Full pass, ready held high
    start = 1'b1;
    run_pass("pass_basic", -1, 0, 1'b0, -1, 465);

    // Backpressure: 10 stalled cycles on tile 5 (row 2, col 4)
    repeat (3) step();
    start = 1'b1;
    run_pass("pass_stall", 5, 10, 1'b0, -1, 475);

    // Randomized ready
    repeat (2) step();
    start = 1'b1;
    run_pass("pass_rand", -1, 0, 1'b1, -1, 0);

    // Abort at tap 12 of tile 2, then restart from tile (0,0)
    repeat (2) step();
    start = 1'b1;
    run_until("abort", 2, 14);
    chk("abort_tap", o_w_addr, 12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    repeat (5) step();
    start = 1'b1;
    run_pass("pass_after_abort", -1, 0, 1'b0, -1, 465);

    // Async reset during DRAIN, then a pass with a stray start mid-run
    start = 1'b1;
    run_until("drain", 3, TAPS + 2);
    rst_n = 1'b0;
    #1;
    m_phase = 0;
    chk_zero("async_rst");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    run_pass("pass_after_rst", -1, 0, 1'b0, 100, 465);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", o_busy, 0);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
